// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : State encoding and counter sizing shared by the serial subtractor.
// Revision : 1.0
// ============================================================================
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // Bit counter must hold 0..w-1 and never collapse to zero width.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ============================================================================
// Module   : full_sub
// Brief    : One-bit combinational full subtractor cell.
// Revision : 1.0
// ============================================================================
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ bin;
    assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial W-bit subtractor (a - b - bin), LSB first, around full_sub.
// Revision : 1.0
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    localparam int                c_cw   = cnt_width(W);
    localparam logic [c_cw-1:0]   c_last = c_cw'(W - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a_sr;
    logic [W-1:0]    r_b_sr;
    logic [W-1:0]    r_res;
    logic [W-1:0]    w_res_nxt;
    logic            r_brw;
    logic [c_cw-1:0] r_cnt;
    logic            w_cell_diff;
    logic            w_cell_borrow;
    logic            w_last;

    full_sub u_cell (
        .a      (r_a_sr[0]),
        .b      (r_b_sr[0]),
        .bin    (r_brw),
        .diff   (w_cell_diff),
        .borrow (w_cell_borrow)
    );

    // New bit enters at the MSB so the first (LSB) result lands at bit 0 after W shifts.
    assign w_res_nxt = (r_res >> 1) | (W'(w_cell_diff) << (W - 1));
    assign w_last    = (r_cnt == c_last);

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_res      <= '0;
            r_brw      <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_brw  <= bin;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_res  <= w_res_nxt;
                    r_brw  <= w_cell_borrow;
                    r_cnt  <= r_cnt + c_cw'(1);
                    if (w_last) begin
                        diff       <= w_res_nxt;
                        borrow_out <= w_cell_borrow;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor at W=8 and W=1.
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bo8;
    logic [7:0] a8, b8, diff8;
    logic       start1, bin1, busy1, done1, bo1;
    logic [0:0] a1, b1, diff1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec8_t;

    exp_t  sb8[$];
    exp_t  sb1[$];
    vec8_t vt[6];

    always #5 clk = ~clk;

    serial_subtractor #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at a negedge with the W=8 DUT idle; returns at the negedge after done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic ebo, input logic hold);
        exp_t       e, got;
        int         nbusy;
        logic [7:0] prev_d;
        logic       prev_bo;
        prev_d  = diff8;
        prev_bo = bo8;
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        e.d = ed; e.bo = ebo;
        sb8.push_back(e);
        @(negedge clk);
        if (!hold) start8 = 1'b0;
        nbusy = 0;
        while (busy8 && nbusy < 40) begin
            nbusy++;
            chk("diff8_stable", diff8, prev_d);
            chk("bo8_stable", bo8, prev_bo);
            if (hold) begin
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            @(negedge clk);
        end
        chk("busy8_cycles", nbusy, 8);
        chk("done8_pulse", done8, 1'b1);
        if (sb8.size() > 0) begin
            got = sb8.pop_front();
            chk("diff8", diff8, got.d);
            chk("borrow8", bo8, got.bo);
        end else begin
            chk("sb8_empty", 0, 1);
        end
        @(negedge clk);
        chk("idle8_busy", busy8, 1'b0);
        chk("idle8_done", done8, 1'b0);
        start8 = 1'b0;
    endtask

    task automatic run1(input logic a, input logic b, input logic bin);
        exp_t       e, got;
        int         nbusy;
        logic [1:0] t;
        t = {1'b0, a} - {1'b0, b} - {1'b0, bin};
        e.d = {7'd0, t[0]}; e.bo = t[1];
        sb1.push_back(e);
        a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nbusy = 0;
        while (busy1 && nbusy < 10) begin
            nbusy++;
            @(negedge clk);
        end
        chk("busy1_cycles", nbusy, 1);
        chk("done1_pulse", done1, 1'b1);
        got = sb1.pop_front();
        chk("diff1", diff1, got.d[0]);
        chk("borrow1", bo1, got.bo);
        @(negedge clk);
        chk("idle1_done", done1, 1'b0);
    endtask

    initial begin
        vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vt[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vt[4] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};
        vt[5] = '{8'h10, 8'h20, 1'b1, 8'hEF, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_done8", done8, 1'b0);
        chk("rst_diff8", diff8, 8'h00);
        chk("rst_bo8", bo8, 1'b0);
        chk("rst_diff1", diff1, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back table run: each start is raised in the first idle cycle.
        for (int i = 0; i < 6; i++)
            run8(vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bo, 1'b0);

        // start held high with operands churning during SHIFT and DONE.
        run8(8'h40, 8'h0F, 1'b0, 8'h31, 1'b0, 1'b1);

        // Asynchronous reset in the 4th SHIFT cycle.
        a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy8", busy8, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy8", busy8, 1'b0);
        chk("arst_done8", done8, 1'b0);
        chk("arst_diff8", diff8, 8'h00);
        chk("arst_bo8", bo8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_hold_done8", done8, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done8", done8, 1'b0);
        chk("post_rst_busy8", busy8, 1'b0);
        run8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

        // W=1: full truth table through the single-bit instance.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run1(v[2], v[1], v[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
